// File: rtl/vga_pkg.sv
// Shared definitions for the VGA palette controller slice.
// Holds default 640x480@60 timing, the packed RGB and sync-stage types,
// and the reset-time greyscale ramp used to preload the palette.
package vga_pkg;

    // Default timing (pixel clocks / lines)
    localparam int H_ACTIVE_DEF     = 640;
    localparam int H_SYNC_START_DEF = 659;
    localparam int H_SYNC_END_DEF   = 754;
    localparam int H_TOTAL_DEF      = 800;
    localparam int V_ACTIVE_DEF     = 480;
    localparam int V_SYNC_START_DEF = 493;
    localparam int V_SYNC_END_DEF   = 494;
    localparam int V_TOTAL_DEF      = 525;

    // Default datapath configuration
    localparam int IDX_W_DEF        = 3;
    localparam int SCALE_SHIFT_DEF  = 1;
    localparam int MEM_LATENCY_DEF  = 1;
    localparam int ADDR_W_DEF       = 17;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    // Per-pixel timing flags carried alongside the colour pipeline.
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
        logic frame_start;
    } sync_t;

    // Idle/reset level of the sync flags: syncs inactive (high), blanked.
    localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0, frame_start: 1'b0};

    // Reset palette: a descending grey ramp, entry 0 white, last entry black.
    function automatic rgb24_t default_palette_entry(input int idx, input int depth);
        int     lvl;
        rgb24_t c;
        if (depth < 2) begin
            lvl = 255;
        end else begin
            lvl = (255 * (depth - 1 - idx)) / (depth - 1);
        end
        c.r = 8'(lvl);
        c.g = 8'(lvl);
        c.b = 8'(lvl);
        return c;
    endfunction

endpackage

// File: rtl/vga_palette_ram.sv
// Purpose: N x 24-bit palette registers with a write port and a registered lookup.
// Latency: rd_dat is valid one clock after rd_idx; a write shows up in lookups from the next clock.
// Backpressure: none; writes are accepted every cycle, lookups are issued every cycle.
//
// Ports:
//   vga_clock, resetn          pixel clock, async active-low reset (reloads the grey ramp)
//   wr_en, wr_addr, wr_dat     palette write port
//   rd_idx, rd_dat             lookup index and registered colour
module vga_palette_ram
    import vga_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             vga_clock,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  rgb24_t           wr_dat,
    input  logic [IDX_W-1:0] rd_idx,
    output rgb24_t           rd_dat
);

    localparam int N = 1 << IDX_W;

    rgb24_t pal [N];

    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                pal[i] <= default_palette_entry(i, N);
            end
        end else if (wr_en) begin
            pal[wr_addr] <= wr_dat;
        end
    end

    // The lookup samples the array on the same edge that performs a write,
    // so a same-cycle read of the written entry returns the old colour.
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            rd_dat <= '0;
        end else begin
            rd_dat <= pal[rd_idx];
        end
    end

endmodule

// File: rtl/vga_palette_controller.sv
// Purpose: VGA raster timing, frame-buffer address generation and palette-mapped RGB output.
// Latency: outputs lag the raster counters by MEM_LATENCY+1 clocks (memory read + palette lookup).
// Backpressure: none; free-running at one pixel per clock, palette writes never stall.
//
// Ports:
//   vga_clock, resetn                  pixel clock, async active-low reset
//   pixel_index                        frame-buffer read data, MEM_LATENCY clocks after memory_address
//   pal_we, pal_addr, pal_data         palette write port, pal_data = {R,G,B}
//   test_mode                          colour-bar enable (only with VGA_TEST_PATTERN_EN)
//   memory_address                     frame-buffer read address
//   VGA_R/G/B, VGA_HS, VGA_VS          colour and syncs (syncs active low)
//   VGA_BLANK_N, VGA_SYNC_N, VGA_CLK   blank (high = visible), sync-on-green off, clock echo
//   frame_start                        one-clock pulse with the output of pixel (0,0)
//
// Build option: define VGA_TEST_PATTERN_EN to add the test_mode input, which
// replaces pixel_index with N equal-width vertical colour bars.
module vga_palette_controller
    import vga_pkg::*;
#(
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int H_SYNC_START = H_SYNC_START_DEF,
    parameter int H_SYNC_END   = H_SYNC_END_DEF,
    parameter int H_TOTAL      = H_TOTAL_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int V_SYNC_START = V_SYNC_START_DEF,
    parameter int V_SYNC_END   = V_SYNC_END_DEF,
    parameter int V_TOTAL      = V_TOTAL_DEF,
    parameter int IDX_W        = IDX_W_DEF,
    parameter int SCALE_SHIFT  = SCALE_SHIFT_DEF,
    parameter int MEM_LATENCY  = MEM_LATENCY_DEF,
    parameter int ADDR_W       = ADDR_W_DEF
) (
    input  logic              vga_clock,
    input  logic              resetn,
    input  logic [IDX_W-1:0]  pixel_index,
    input  logic              pal_we,
    input  logic [IDX_W-1:0]  pal_addr,
    input  logic [23:0]       pal_data,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    output logic [ADDR_W-1:0] memory_address,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_N,
    output logic              VGA_SYNC_N,
    output logic              VGA_CLK,
    output logic              frame_start
);

    localparam int D        = MEM_LATENCY + 1;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int ROW_DOTS = H_ACTIVE >> SCALE_SHIFT;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_C = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS_C  = HW'(H_SYNC_START);
    localparam logic [HW-1:0] H_SE_C  = HW'(H_SYNC_END);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS_C  = VW'(V_SYNC_START);
    localparam logic [VW-1:0] V_SE_C  = VW'(V_SYNC_END);

    logic [HW-1:0]    hcnt;
    logic [VW-1:0]    vcnt;
    sync_t            sync_c;
    sync_t            sync_pipe [D];
    logic [IDX_W-1:0] lookup_idx;
    rgb24_t           pal_rd;

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    // Frame-buffer address of the dot under the counters. Each dot spans
    // 2**SCALE_SHIFT pixels in both directions; outside the visible area the
    // value is meaningless and simply left unmasked.
    assign memory_address = ADDR_W'(vcnt >> SCALE_SHIFT) * ADDR_W'(ROW_DOTS)
                          + ADDR_W'(hcnt >> SCALE_SHIFT);

    // ------------------------------------------------------------------
    // Sync/blank flags at the counter stage, then delayed D clocks so they
    // leave together with the colour of the same pixel.
    // ------------------------------------------------------------------
    always_comb begin
        sync_c             = SYNC_RST;
        sync_c.hs          = !((hcnt >= H_SS_C) && (hcnt <= H_SE_C));
        sync_c.vs          = !((vcnt >= V_SS_C) && (vcnt <= V_SE_C));
        sync_c.blank_n     = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
        sync_c.frame_start = (hcnt == '0) && (vcnt == '0);
    end

    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < D; i++) begin
                sync_pipe[i] <= SYNC_RST;
            end
        end else begin
            sync_pipe[0] <= sync_c;
            for (int i = 1; i < D; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Palette index source
    // ------------------------------------------------------------------
`ifdef VGA_TEST_PATTERN_EN
    localparam int TPW = HW + IDX_W;

    logic [TPW-1:0]   tp_prod;
    logic [TPW-1:0]   tp_quot;
    logic [IDX_W-1:0] tp_idx;
    logic [IDX_W-1:0] tp_pipe [MEM_LATENCY];

    // Bar number = floor(hcnt*N/H_ACTIVE); the divisor is a constant.
    assign tp_prod = TPW'(hcnt) << IDX_W;
    assign tp_quot = tp_prod / TPW'(H_ACTIVE);
    assign tp_idx  = (hcnt < H_ACT_C) ? IDX_W'(tp_quot) : '0;

    // The bar index is delayed by the memory latency so it arrives at the
    // lookup on the same clock that pixel_index would have.
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                tp_pipe[i] <= '0;
            end
        end else begin
            tp_pipe[0] <= tp_idx;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tp_pipe[i] <= tp_pipe[i-1];
            end
        end
    end

    assign lookup_idx = test_mode ? tp_pipe[MEM_LATENCY-1] : pixel_index;
`else
    assign lookup_idx = pixel_index;
`endif

    // ------------------------------------------------------------------
    // Palette and output
    // ------------------------------------------------------------------
    vga_palette_ram #(
        .IDX_W (IDX_W)
    ) u_palette (
        .vga_clock (vga_clock),
        .resetn    (resetn),
        .wr_en     (pal_we),
        .wr_addr   (pal_addr),
        .wr_dat    (rgb24_t'(pal_data)),
        .rd_idx    (lookup_idx),
        .rd_dat    (pal_rd)
    );

    // Colour is forced to black whenever the aligned blank flag is low, which
    // also covers the reset state since both the flag and lookup clear.
    assign VGA_R       = sync_pipe[D-1].blank_n ? pal_rd.r : 8'd0;
    assign VGA_G       = sync_pipe[D-1].blank_n ? pal_rd.g : 8'd0;
    assign VGA_B       = sync_pipe[D-1].blank_n ? pal_rd.b : 8'd0;
    assign VGA_HS      = sync_pipe[D-1].hs;
    assign VGA_VS      = sync_pipe[D-1].vs;
    assign VGA_BLANK_N = sync_pipe[D-1].blank_n;
    assign frame_start = sync_pipe[D-1].frame_start;
    assign VGA_SYNC_N  = 1'b1;
    assign VGA_CLK     = vga_clock;

endmodule

// File: tb/tb_vga_palette_controller.sv
// Bench for vga_palette_controller: full 640-pixel lines with a shortened
// 32-line frame, MEM_LATENCY=2 and SCALE_SHIFT=2. A reference raster feeds a
// scoreboard queue; a negedge monitor pops and compares every output clock.
module tb_vga_palette_controller;

    localparam int HA = 640, HSS = 659, HSE = 754, HT = 800;
    localparam int VA = 24,  VSS = 27,  VSE = 28,  VT = 32;
    localparam int L  = 2;
    localparam int S  = 2;

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        bn;
        logic        fs;
        logic [16:0] addr;
        logic [9:0]  hx;
    } exp_t;

    logic        vga_clock;
    logic        resetn;
    logic [2:0]  pixel_index;
    logic        pal_we;
    logic [2:0]  pal_addr;
    logic [23:0] pal_data;
    logic        tm_val;
    logic [16:0] memory_address;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;
    logic        frame_start;

    vga_palette_controller #(
        .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
        .IDX_W(3), .SCALE_SHIFT(S), .MEM_LATENCY(L), .ADDR_W(17)
    ) dut (
        .vga_clock      (vga_clock),
        .resetn         (resetn),
        .pixel_index    (pixel_index),
        .pal_we         (pal_we),
        .pal_addr       (pal_addr),
        .pal_data       (pal_data),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode      (tm_val),
`endif
        .memory_address (memory_address),
        .VGA_R          (VGA_R),
        .VGA_G          (VGA_G),
        .VGA_B          (VGA_B),
        .VGA_HS         (VGA_HS),
        .VGA_VS         (VGA_VS),
        .VGA_BLANK_N    (VGA_BLANK_N),
        .VGA_SYNC_N     (VGA_SYNC_N),
        .VGA_CLK        (VGA_CLK),
        .frame_start    (frame_start)
    );

    initial vga_clock = 1'b0;
    always #5 vga_clock = ~vga_clock;

    exp_t        sbq [$];
    exp_t        ehist [L];
    logic [16:0] ahist [L];
    logic [23:0] pal_m [8];
    int          ref_h, ref_v;
    int          mem_mode;
    int          checks, errors;
    bit          sb_on;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t rst_exp();
        exp_t e;
        e      = '0;
        e.hs   = 1'b1;
        e.vs   = 1'b1;
        return e;
    endfunction

    // Frame-buffer contents: constant 3, constant 5, or an address hash.
    function automatic logic [2:0] mem_fn(input logic [16:0] a);
        logic [16:0] t;
        case (mem_mode)
            0:       return 3'd3;
            2:       return 3'd5;
            default: begin
                t = a ^ (a >> 3) ^ (a >> 6);
                return t[2:0];
            end
        endcase
    endfunction

    function automatic exp_t cur_exp();
        exp_t c;
        c      = '0;
        c.hs   = !((ref_h >= HSS) && (ref_h <= HSE));
        c.vs   = !((ref_v >= VSS) && (ref_v <= VSE));
        c.bn   = (ref_h < HA) && (ref_v < VA);
        c.fs   = (ref_h == 0) && (ref_v == 0);
        c.addr = 17'((ref_v >> S) * (HA >> S) + (ref_h >> S));
        c.hx   = 10'(ref_h);
        return c;
    endfunction

    // Process the current clock (inputs already set by caller), then advance.
    task automatic cycle();
        exp_t       e;
        exp_t       c;
        logic [2:0] idx;
        if (!resetn) begin
            sbq.push_back(rst_exp());
            pixel_index = 3'd0;
        end else begin
            c = cur_exp();
            e = ehist[L-1];
            idx = mem_fn(e.addr);
`ifdef VGA_TEST_PATTERN_EN
            if (tm_val) idx = 3'((int'(e.hx) * 8) / HA);
`endif
            e.rgb = e.bn ? pal_m[idx] : 24'h0;
            sbq.push_back(e);
            pixel_index = mem_fn(ahist[L-1]);
            if (c.bn) chk("mem_addr", 32'(memory_address), 32'(c.addr));
            for (int k = L-1; k > 0; k--) begin
                ehist[k] = ehist[k-1];
                ahist[k] = ahist[k-1];
            end
            ehist[0] = c;
            ahist[0] = memory_address;
            if (pal_we) pal_m[pal_addr] = pal_data;
            ref_h++;
            if (ref_h == HT) begin
                ref_h = 0;
                ref_v++;
                if (ref_v == VT) ref_v = 0;
            end
        end
        @(posedge vga_clock);
        #1;
    endtask

    task automatic run_to(input int h, input int v);
        bit hit;
        hit = 0;
        for (int i = 0; i < 40000; i++) begin
            if (ref_h == h && ref_v == v) begin
                hit = 1;
                break;
            end
            cycle();
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL run_to_timeout actual=%0d,%0d required=%0d,%0d", ref_h, ref_v, h, v);
        end
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        #1;
        chk("rst_rgb",   {VGA_R, VGA_G, VGA_B}, 24'h0);
        chk("rst_hs",    VGA_HS, 1);
        chk("rst_vs",    VGA_VS, 1);
        chk("rst_blank", VGA_BLANK_N, 0);
        chk("rst_fs",    frame_start, 0);
        chk("rst_syncn", VGA_SYNC_N, 1);
        chk("rst_addr",  memory_address, 0);
        sbq.delete();
        sbq.push_back(rst_exp());
        sb_on = 1;
        for (int k = 0; k < L; k++) begin
            ehist[k] = rst_exp();
            ahist[k] = '0;
        end
        pal_m[0] = 24'hFFFFFF; pal_m[1] = 24'hDADADA; pal_m[2] = 24'hB6B6B6; pal_m[3] = 24'h919191;
        pal_m[4] = 24'h6D6D6D; pal_m[5] = 24'h484848; pal_m[6] = 24'h242424; pal_m[7] = 24'h000000;
        ref_h = 0;
        ref_v = 0;
        repeat (n) cycle();
        resetn = 1'b1;
    endtask

    // Monitor: per-clock scoreboard compare plus per-line/per-frame tallies.
    exp_t mon_e;
    int   hs_run, blank_cnt, vs_cnt;
    bit   have_frame;

    always @(negedge vga_clock) begin
        if (sb_on) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow actual=empty required=entry t=%0t", $time);
            end else begin
                mon_e = sbq.pop_front();
                checks++;
                if ({VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start}
                    !== {mon_e.rgb, mon_e.hs, mon_e.vs, mon_e.bn, mon_e.fs}) begin
                    errors++;
                    $display("FAIL sb_pixel t=%0t actual rgb=%06h hs=%b vs=%b bn=%b fs=%b required rgb=%06h hs=%b vs=%b bn=%b fs=%b",
                             $time, {VGA_R, VGA_G, VGA_B}, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start,
                             mon_e.rgb, mon_e.hs, mon_e.vs, mon_e.bn, mon_e.fs);
                end
            end
            if (!resetn) begin
                have_frame = 0;
                hs_run     = 0;
            end else begin
                if (frame_start) begin
                    if (have_frame) begin
                        chk("frame_blank_cnt", blank_cnt, HA * VA);
                        chk("frame_vs_low",    vs_cnt,    2 * HT);
                    end
                    have_frame = 1;
                    blank_cnt  = 0;
                    vs_cnt     = 0;
                end
                if (VGA_BLANK_N) blank_cnt++;
                if (!VGA_VS) vs_cnt++;
                if (!VGA_HS) begin
                    hs_run++;
                end else if (hs_run != 0) begin
                    chk("hs_low_width", hs_run, 96);
                    hs_run = 0;
                end
            end
        end
    end

    initial begin
        resetn      = 1'b0;
        pixel_index = 3'd0;
        pal_we      = 1'b0;
        pal_addr    = 3'd0;
        pal_data    = 24'h0;
        tm_val      = 1'b0;
        mem_mode    = 0;
        checks      = 0;
        errors      = 0;
        sb_on       = 0;
        hs_run      = 0;
        blank_cnt   = 0;
        vs_cnt      = 0;
        have_frame  = 0;
        @(posedge vga_clock);
        #1;
        do_reset(4);

        // First pixel: index 3 -> 0x919191, three clocks after address 0.
        chk("first_addr", memory_address, 0);
        cycle();
        cycle();
        chk("first_blank_early", VGA_BLANK_N, 0);
        cycle();
        chk("first_rgb",   {VGA_R, VGA_G, VGA_B}, 24'h919191);
        chk("first_blank", VGA_BLANK_N, 1);
        chk("first_fs",    frame_start, 1);
        cycle();
        chk("fs_one_clock", frame_start, 0);

        mem_mode = 1;
        run_to(13, 9);
        chk("addr_13_9", memory_address, 323);

        // Palette write mid-line with the frame buffer returning index 5.
        run_to(100, 10);
        mem_mode = 2;
        run_to(200, 10);
        pal_addr = 3'd5;
        pal_data = 24'hFF0000;
        pal_we   = 1'b1;
        chk("pal_before_write", {VGA_R, VGA_G, VGA_B}, 24'h484848);
        cycle();
        pal_we   = 1'b0;
        chk("pal_write_cycle",  {VGA_R, VGA_G, VGA_B}, 24'h484848);
        cycle();
        chk("pal_after_write",  {VGA_R, VGA_G, VGA_B}, 24'hFF0000);

        mem_mode = 1;
        run_to(0, 0);
`ifdef VGA_TEST_PATTERN_EN
        run_to(0, 2);
        tm_val = 1'b1;
        run_to(43, 3);
        chk("bar_white", {VGA_R, VGA_G, VGA_B}, 24'hFFFFFF);
        run_to(603, 3);
        chk("bar_black", {VGA_R, VGA_G, VGA_B}, 24'h000000);
        run_to(0, 5);
        tm_val = 1'b0;
`endif
        // Mid-frame reset, then the grey ramp must be back for index 5.
        run_to(300, 20);
        do_reset(5);
        mem_mode = 2;
        chk("restart_addr", memory_address, 0);
        cycle();
        cycle();
        cycle();
        chk("restart_rgb", {VGA_R, VGA_G, VGA_B}, 24'h484848);
        chk("restart_fs",  frame_start, 1);
        mem_mode = 1;
        run_to(0, 3);

        @(negedge vga_clock);
        #1;
        sb_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_palette_controller.md
VGA_PALETTE_CONTROLLER -- requirements
Module: vga_palette_controller

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameters H_SYNC_START, H_SYNC_END, H_TOTAL: 659, 754, 800; inclusive HS-low range and line length in clocks.
REQ-003 Parameters V_ACTIVE, V_SYNC_START, V_SYNC_END, V_TOTAL: 480, 493, 494, 525; same semantics in lines.
REQ-004 Parameter IDX_W, 3, palette index width; palette depth N = 2**IDX_W.
REQ-005 Parameter SCALE_SHIFT, 1 (legal 0..2); each frame-buffer dot covers 2**SCALE_SHIFT screen pixels in x and y.
REQ-006 Parameter MEM_LATENCY, 1 (legal 1..3); clocks from memory_address to pixel_index valid.
REQ-007 Parameter ADDR_W, 17, memory_address width.
REQ-008 vga_clock in 1: pixel clock. resetn in 1: asynchronous, active-low reset.
REQ-009 pixel_index in IDX_W: frame-buffer read data.
REQ-010 pal_we in 1, pal_addr in IDX_W, pal_data in 24 {R,G,B}: palette write port.
REQ-011 memory_address out ADDR_W: frame-buffer read address.
REQ-012 VGA_R, VGA_G, VGA_B out 8 each; VGA_HS, VGA_VS, VGA_BLANK_N out 1; VGA_SYNC_N out 1, tied 1; VGA_CLK out 1, equals vga_clock.
REQ-013 frame_start out 1: one-cycle pulse.

Function
REQ-014 hcnt counts 0..H_TOTAL-1 and wraps to 0; vcnt increments on the hcnt wrap and wraps to 0 after V_TOTAL-1.
REQ-015 memory_address = (vcnt>>S)*(H_ACTIVE>>S) + (hcnt>>S), S=SCALE_SHIFT, truncated to ADDR_W; the value is don't-care outside the active region.
REQ-016 Total pipeline depth D = MEM_LATENCY+1 (memory read plus registered palette lookup); HS, VS and blank are delayed D clocks so that every output corresponds to the same (hcnt,vcnt).
REQ-017 HS is low iff H_SYNC_START<=hcnt<=H_SYNC_END; VS is low iff V_SYNC_START<=vcnt<=V_SYNC_END; BLANK_N is high iff hcnt<H_ACTIVE and vcnt<V_ACTIVE; all are evaluated at the counter stage and then delayed by D.
REQ-018 RGB equals the palette[pixel_index] entry while the delayed BLANK_N is 1, and 0 otherwise.
REQ-019 Palette: N x 24-bit registers, with a synchronous write when pal_we=1.
REQ-020 A write is visible to lookups from the clock after the write edge. A same-cycle read of the same entry returns the old value.
REQ-021 A write to any entry is legal at any time; there is no handshake and no stall.
REQ-022 frame_start is 1 for exactly one clock, coincident with the output of pixel (0,0).

Reset
REQ-023 During reset: hcnt=vcnt=0, all pipeline stages cleared, RGB=0, HS=1, VS=1, BLANK_N=0, frame_start=0.
REQ-024 During reset, palette entry i on all three channels = floor(255*(N-1-i)/(N-1)); for N=8 this gives 255,218,182,145,109,72,36,0.
REQ-025 Reset asserted mid-frame aborts the frame. After release, scanning restarts at (0,0), and frame_start fires D clocks after release.

Configuration
REQ-026 Macro VGA_TEST_PATTERN_EN defined: adds input test_mode (1 bit). When test_mode=1, the pixel_index input is ignored and the lookup index = floor(hcnt*N/H_ACTIVE) for active pixels, giving N equal vertical colour bars. Pipeline alignment is identical to REQ-016.
REQ-027 Macro VGA_TEST_PATTERN_EN undefined: test_mode does not exist, and the lookup index always comes from pixel_index.

Structure
REQ-028 Shared package vga_pkg holds:
- default timing constants;
- typedef rgb24_t for the packed {R,G,B} value;
- a helper function for the default palette of REQ-024.
REQ-029 The palette storage, write port and registered lookup live in sub-module vga_palette_ram; counters, address generation and sync pipeline stay in the top module.

Verification
REQ-030 Release reset, run one frame at defaults → HS low for 96 clocks per 800-clock line; VS low for lines 493-494; 307200 BLANK_N-high clocks per frame.
REQ-031 Hold pixel_index=3, MEM_LATENCY=2 → first active output is RGB=0x919191, exactly 3 clocks after memory_address=0; frame_start is coincident with that output.
REQ-032 Write pal_addr=5, pal_data=0xFF0000 mid-line while pixel_index=5 → the old value 0x484848 persists through the write cycle, then 0xFF0000 appears one clock later.
REQ-033 SCALE_SHIFT=2, at hcnt=13, vcnt=9 → memory_address=2*160+3=323.
REQ-034 Assert resetn at hcnt=300, vcnt=200 for 5 clocks → outputs take the REQ-023 values at once; after release, counting starts at (0,0), and the REQ-024 palette is restored after an earlier write.
REQ-035 With VGA_TEST_PATTERN_EN and test_mode=1 → pixels 0-79 are white, and pixels 560-639 are black on every active line.
